// File: rtl/jtsbaskt_pkg.sv
// Shared constants for the sound-CPU bridge.
package jtsbaskt_pkg;

  // VLM5030 control register bit positions
  localparam int unsigned VLM_SEL = 0;
  localparam int unsigned VLM_RST = 1;
  localparam int unsigned VLM_ST  = 2;

  // Upper nibble returned with every timer read
  localparam logic [3:0] TIMER_HI = 4'hF;

  // Default prescaler exponent for the polled timer
  localparam int unsigned DEF_TIMER_DIV = 10;

endpackage

// File: rtl/jtsbaskt_snd_if_if.sv
// Bus bundle between the main/sound CPU decoders and the bridge.
interface jtsbaskt_snd_if_if;
  // main 6809 side
  logic       main_cen;
  logic       main_rnw;
  logic [7:0] main_dout;
  logic       snd_data_cs;
  logic       snd_on_cs;
  // Z80 side
  logic       snd_cen;
  logic       snd_wrn;
  logic       snd_rdn;
  logic       snd_ack;
  logic       latch_cs;
  logic       timer_cs;
  logic       vlmd_cs;
  logic       vlmc_cs;
  logic [7:0] snd_din;
  logic [7:0] snd_dout;
  logic       snd_irqn;

  modport master (
    output main_cen, main_rnw, main_dout, snd_data_cs, snd_on_cs,
    output snd_cen, snd_wrn, snd_rdn, snd_ack, latch_cs, timer_cs, vlmd_cs, vlmc_cs, snd_din,
    input  snd_dout, snd_irqn
  );

  modport slave (
    input  main_cen, main_rnw, main_dout, snd_data_cs, snd_on_cs,
    input  snd_cen, snd_wrn, snd_rdn, snd_ack, latch_cs, timer_cs, vlmd_cs, vlmc_cs, snd_din,
    output snd_dout, snd_irqn
  );
endinterface

// File: rtl/jtsbaskt_snd_irq.sv
// Sound IRQ flip-flop: set by the main CPU, cleared by the Z80 acknowledge.
module jtsbaskt_snd_irq (
  input  logic clk,
  input  logic rstn,
  input  logic set,
  input  logic clr,
  output logic irqn
);

  // Set has priority so a request landing on the ack cycle is not lost
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irqn <= 1'b1;
    end else if (set) begin
      irqn <= 1'b0;
    end else if (clr) begin
      irqn <= 1'b1;
    end
  end

endmodule

// File: rtl/jtsbaskt_snd_if.sv
// Main 6809 to Z80 sound bridge: command latch, IRQ handshake, timer, VLM registers.
// CNT_W must be at least TIMER_DIV+4.
module jtsbaskt_snd_if
  import jtsbaskt_pkg::*;
#(
  parameter int unsigned TIMER_DIV = DEF_TIMER_DIV,
  parameter int unsigned CNT_W     = 14
) (
  input  logic                 clk,
  input  logic                 rstn,
  jtsbaskt_snd_if_if.slave     bus,
  output logic                 fresh,
  output logic [7:0]           vlm_data,
  output logic                 vlm_st,
  output logic                 vlm_rst,
  output logic                 vlm_sel
);

  logic [7:0]       latch_q;
  logic             fresh_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       dout_d, dout_q;
  logic             main_wr, latch_wr, irq_set, irq_clr, latch_rd, irqn;

  assign main_wr  = bus.main_cen & ~bus.main_rnw;
  assign latch_wr = main_wr & bus.snd_data_cs;
  assign irq_set  = main_wr & bus.snd_on_cs;
  assign irq_clr  = bus.snd_cen & bus.snd_ack;
  assign latch_rd = ~bus.snd_rdn & bus.latch_cs;

  // Command latch and its "unread" flag; a main write beats a Z80 read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      latch_q <= 8'h00;
      fresh_q <= 1'b0;
    end else begin
      if (latch_wr) begin
        latch_q <= bus.main_dout;
      end
      if (latch_wr) begin
        fresh_q <= 1'b1;
      end else if (latch_rd && bus.snd_cen) begin
        fresh_q <= 1'b0;
      end
    end
  end

  // Free-running counter advanced by the sound clock enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (bus.snd_cen) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Read mux: latch has priority over the timer, idle bus reads FF
  always_comb begin
    dout_d = 8'hFF;
    if (latch_rd) begin
      dout_d = latch_q;
    end else if (!bus.snd_rdn && bus.timer_cs) begin
      dout_d = {TIMER_HI, cnt_q[TIMER_DIV+3:TIMER_DIV]};
    end
  end

  // Read data registered every clk so it settles well before the next snd_cen
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= 8'hFF;
    end else begin
      dout_q <= dout_d;
    end
  end

  // VLM5030 data and control registers, written by the Z80
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vlm_data <= 8'h00;
      vlm_sel  <= 1'b0;
      vlm_rst  <= 1'b1;
      vlm_st   <= 1'b0;
    end else if (bus.snd_cen && !bus.snd_wrn) begin
      if (bus.vlmd_cs) begin
        vlm_data <= bus.snd_din;
      end
      if (bus.vlmc_cs) begin
        vlm_sel <= bus.snd_din[VLM_SEL];
        vlm_rst <= bus.snd_din[VLM_RST];
        vlm_st  <= bus.snd_din[VLM_ST];
      end
    end
  end

  jtsbaskt_snd_irq u_irq (
    .clk  (clk),
    .rstn (rstn),
    .set  (irq_set),
    .clr  (irq_clr),
    .irqn (irqn)
  );

  assign bus.snd_dout = dout_q;
  assign bus.snd_irqn = irqn;
  assign fresh        = fresh_q;

endmodule

// File: tb/tb_jtsbaskt_snd_if.sv
// Directed bench for the sound bridge.
module tb_jtsbaskt_snd_if;

  logic       clk = 1'b0;
  logic       rstn;
  logic       fresh, vlm_st, vlm_rst, vlm_sel;
  logic [7:0] vlm_data;
  int         n_vec = 0;
  int         n_bad = 0;

  jtsbaskt_snd_if_if bus ();

  jtsbaskt_snd_if #(
    .TIMER_DIV (10),
    .CNT_W     (14)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .fresh    (fresh),
    .vlm_data (vlm_data),
    .vlm_st   (vlm_st),
    .vlm_rst  (vlm_rst),
    .vlm_sel  (vlm_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.main_cen    = 1'b0;
    bus.main_rnw    = 1'b1;
    bus.main_dout   = 8'h00;
    bus.snd_data_cs = 1'b0;
    bus.snd_on_cs   = 1'b0;
    bus.snd_cen     = 1'b0;
    bus.snd_wrn     = 1'b1;
    bus.snd_rdn     = 1'b1;
    bus.snd_ack     = 1'b0;
    bus.latch_cs    = 1'b0;
    bus.timer_cs    = 1'b0;
    bus.vlmd_cs     = 1'b0;
    bus.vlmc_cs     = 1'b0;
    bus.snd_din     = 8'h00;
  endtask

  task automatic main_write_latch(input logic [7:0] d);
    bus.snd_data_cs = 1'b1;
    bus.main_rnw    = 1'b0;
    bus.main_dout   = d;
    bus.main_cen    = 1'b1;
    tick();
    idle();
  endtask

  task automatic main_write_on();
    bus.snd_on_cs = 1'b1;
    bus.main_rnw  = 1'b0;
    bus.main_dout = 8'hA5;
    bus.main_cen  = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    tick(2);
    // reset values
    check("rst_dout", bus.snd_dout, 8'hFF);
    check("rst_irqn", {7'd0, bus.snd_irqn}, 8'h01);
    check("rst_fresh", {7'd0, fresh}, 8'h00);
    check("rst_vlm_data", vlm_data, 8'h00);
    check("rst_vlm_ctl", {5'd0, vlm_st, vlm_rst, vlm_sel}, 8'h02);
    rstn = 1'b1;
    tick();

    // latch write, then strobe held without cen must not overwrite it
    main_write_latch(8'h5A);
    check("fresh_set", {7'd0, fresh}, 8'h01);
    bus.snd_data_cs = 1'b1;
    bus.main_rnw    = 1'b0;
    bus.main_dout   = 8'h77;
    tick(3);
    idle();

    // Z80 latch read: data after 1 clk, fresh clears only on snd_cen
    bus.latch_cs = 1'b1;
    bus.snd_rdn  = 1'b0;
    tick();
    check("latch_rd", bus.snd_dout, 8'h5A);
    check("fresh_no_cen", {7'd0, fresh}, 8'h01);
    bus.snd_cen = 1'b1;
    tick();
    bus.snd_cen = 1'b0;
    check("fresh_clr", {7'd0, fresh}, 8'h00);
    idle();
    tick();
    check("idle_dout", bus.snd_dout, 8'hFF);

    // IRQ raise, ack without cen ignored, ack with cen clears, re-raise
    main_write_on();
    check("irq_set", {7'd0, bus.snd_irqn}, 8'h00);
    bus.snd_ack = 1'b1;
    tick();
    check("irq_ack_no_cen", {7'd0, bus.snd_irqn}, 8'h00);
    bus.snd_cen = 1'b1;
    tick();
    idle();
    check("irq_clr", {7'd0, bus.snd_irqn}, 8'h01);
    main_write_on();
    check("irq_reset2", {7'd0, bus.snd_irqn}, 8'h00);
    main_write_on();
    check("irq_pending_wr", {7'd0, bus.snd_irqn}, 8'h00);

    // clear, then set and clear on the same clk: set wins
    bus.snd_ack = 1'b1;
    bus.snd_cen = 1'b1;
    tick();
    idle();
    check("irq_clr2", {7'd0, bus.snd_irqn}, 8'h01);
    bus.snd_on_cs = 1'b1;
    bus.main_rnw  = 1'b0;
    bus.main_cen  = 1'b1;
    bus.snd_ack   = 1'b1;
    bus.snd_cen   = 1'b1;
    tick();
    idle();
    check("irq_set_wins", {7'd0, bus.snd_irqn}, 8'h00);

    // VLM registers
    bus.snd_wrn = 1'b0;
    bus.vlmc_cs = 1'b1;
    bus.snd_din = 8'h07;
    bus.snd_cen = 1'b1;
    tick();
    idle();
    bus.snd_wrn = 1'b0;
    bus.vlmd_cs = 1'b1;
    bus.snd_din = 8'hC3;
    bus.snd_cen = 1'b1;
    tick();
    idle();
    check("vlm_ctl_07", {5'd0, vlm_st, vlm_rst, vlm_sel}, 8'h07);
    check("vlm_data_c3", vlm_data, 8'hC3);
    bus.snd_wrn = 1'b0;
    bus.vlmd_cs = 1'b1;
    bus.snd_din = 8'h55;
    tick(3);
    idle();
    check("vlm_data_no_cen", vlm_data, 8'hC3);
    bus.snd_wrn = 1'b0;
    bus.vlmc_cs = 1'b1;
    bus.snd_din = 8'h01;
    bus.snd_cen = 1'b1;
    tick();
    idle();
    check("vlm_ctl_01", {5'd0, vlm_st, vlm_rst, vlm_sel}, 8'h01);

    // main write and Z80 read on the same clk: old data, fresh stays set
    main_write_latch(8'h22);
    bus.latch_cs    = 1'b1;
    bus.snd_rdn     = 1'b0;
    bus.snd_cen     = 1'b1;
    bus.snd_data_cs = 1'b1;
    bus.main_rnw    = 1'b0;
    bus.main_dout   = 8'h11;
    bus.main_cen    = 1'b1;
    tick();
    check("race_dout", bus.snd_dout, 8'h22);
    check("race_fresh", {7'd0, fresh}, 8'h01);
    bus.snd_data_cs = 1'b0;
    bus.main_cen    = 1'b0;
    bus.main_rnw    = 1'b1;
    bus.snd_cen     = 1'b0;
    tick();
    check("race_next_rd", bus.snd_dout, 8'h11);
    idle();

    // timer: 5*1024 snd_cen pulses from reset
    do_reset();
    bus.snd_cen = 1'b1;
    tick(5120);
    bus.snd_cen  = 1'b0;
    bus.timer_cs = 1'b1;
    bus.snd_rdn  = 1'b0;
    tick();
    check("timer_f5", bus.snd_dout, 8'hF5);
    bus.latch_cs = 1'b1;
    tick();
    check("latch_prio", bus.snd_dout, 8'h00);
    idle();
    bus.snd_cen = 1'b1;
    tick(16383 - 5120);
    bus.snd_cen  = 1'b0;
    bus.timer_cs = 1'b1;
    bus.snd_rdn  = 1'b0;
    tick();
    check("timer_ff", bus.snd_dout, 8'hFF);
    bus.snd_cen = 1'b1;
    tick();
    bus.snd_cen = 1'b0;
    tick();
    check("timer_wrap", bus.snd_dout, 8'hF0);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
